snn_io_pipeline: RTL

- Parametrised boundary retiming block placed between the chip pads and the SNN core.
- Gives the streaming input path full valid/ready register slices: ready is registered, throughput is full, and nothing is lost under backpressure.
- Gives the start/sideband inputs and the status outputs plain configurable-depth delay lines.
- Adds synchronous flush and an occupancy report, which plain fixed-depth flop buffering does not provide.

---
 rtl/snn_io_pipeline_if.sv | 26 ++
 rtl/snn_io_pipeline.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/snn_io_pipeline_if.sv
// Streaming boundary bundle: upstream word handshake, downstream word handshake, flush and occupancy.
interface snn_io_pipeline_if #(
   parameter int DATA_WIDTH = 66,
   parameter int FWD_STAGES = 2
);
   localparam int OCC_W = $clog2(2*FWD_STAGES+1);

   logic                  s_valid_i;
   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  s_ready_o;
   logic                  m_valid_o;
   logic [DATA_WIDTH-1:0] m_data_o;
   logic                  m_ready_i;
   logic                  flush_i;
   logic [OCC_W-1:0]      occupancy_o;

   modport master (
      output s_valid_i, s_data_i, m_ready_i, flush_i,
      input  s_ready_o, m_valid_o, m_data_o, occupancy_o
   );

   modport slave (
      input  s_valid_i, s_data_i, m_ready_i, flush_i,
      output s_ready_o, m_valid_o, m_data_o, occupancy_o
   );
endinterface

// File: rtl/snn_io_pipeline.sv
// Pad-to-core retiming: FWD_STAGES skid slices (word out FWD_STAGES-1 edges after acceptance), plus sideband/status delay lines.
// Backpressure: every slice ready is flop-derived, so a stalled core never creates a combinational path back to the pads.
module snn_io_pipeline #(
   parameter int DATA_WIDTH      = 66,
   parameter int FWD_STAGES      = 2,
   parameter int SIDEBAND_WIDTH  = 2,
   parameter int SIDEBAND_STAGES = 2,
   parameter int STATUS_WIDTH    = 2,
   parameter int STATUS_STAGES   = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   snn_io_pipeline_if.slave          str,
   input  logic [SIDEBAND_WIDTH-1:0] sb_i,
   output logic [SIDEBAND_WIDTH-1:0] sb_o,
   input  logic [STATUS_WIDTH-1:0]   st_i,
   output logic [STATUS_WIDTH-1:0]   st_o
);
   localparam int OCC_W = $clog2(2*FWD_STAGES+1);

   if (FWD_STAGES < 1 || FWD_STAGES > 4) begin : g_bad_fwd
      $error("snn_io_pipeline: FWD_STAGES must be 1..4");
   end
   if (SIDEBAND_STAGES < 0 || SIDEBAND_STAGES > 4) begin : g_bad_sb
      $error("snn_io_pipeline: SIDEBAND_STAGES must be 0..4");
   end
   if (STATUS_STAGES < 0 || STATUS_STAGES > 4) begin : g_bad_st
      $error("snn_io_pipeline: STATUS_STAGES must be 0..4");
   end

   typedef enum logic [1:0] {SL_EMPTY, SL_ONE, SL_FULL} slice_st_e;

   slice_st_e             slc_q [FWD_STAGES];
   slice_st_e             slc_d [FWD_STAGES];
   logic                  en_q;
   logic [FWD_STAGES-1:0] main_vld, skid_vld, in_rdy, take_in, take_out;
   logic [FWD_STAGES-1:0] ld_main, ld_skid, ld_from_skid;
   logic [FWD_STAGES:0]   vld_chain, rdy_chain;
   logic [DATA_WIDTH-1:0] dat_chain [FWD_STAGES+1];
   logic [DATA_WIDTH-1:0] main_dat  [FWD_STAGES];
   logic [DATA_WIDTH-1:0] skid_dat  [FWD_STAGES];
   logic [OCC_W-1:0]      occ;

   // Ready stays low until the first edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) en_q <= 1'b0;
      else          en_q <= 1'b1;
   end

   // Chain index k is slice k's in-side; index FWD_STAGES is the core side.
   always_comb begin
      vld_chain    = '0;
      rdy_chain    = '0;
      dat_chain    = '{default: '0};
      main_vld     = '0;
      skid_vld     = '0;
      in_rdy       = '0;
      take_in      = '0;
      take_out     = '0;
      occ          = '0;
      vld_chain[0] = str.s_valid_i;
      dat_chain[0] = str.s_data_i;
      rdy_chain[FWD_STAGES] = str.m_ready_i;
      for (int k = 0; k < FWD_STAGES; k++) begin
         main_vld[k]    = (slc_q[k] != SL_EMPTY);
         skid_vld[k]    = (slc_q[k] == SL_FULL);
         in_rdy[k]      = en_q && !skid_vld[k];
         vld_chain[k+1] = main_vld[k];
         rdy_chain[k]   = in_rdy[k];
         dat_chain[k+1] = main_dat[k];
         occ            = occ + OCC_W'(main_vld[k]) + OCC_W'(skid_vld[k]);
      end
      for (int k = 0; k < FWD_STAGES; k++) begin
         take_in[k]  = vld_chain[k] && in_rdy[k];
         take_out[k] = main_vld[k] && rdy_chain[k+1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < FWD_STAGES; k++) slc_q[k] <= SL_EMPTY;
      end else begin
         for (int k = 0; k < FWD_STAGES; k++) slc_q[k] <= slc_d[k];
      end
   end

   always_comb begin
      for (int k = 0; k < FWD_STAGES; k++) begin
         slc_d[k] = slc_q[k];
         if (str.flush_i) begin
            slc_d[k] = SL_EMPTY;
         end else begin
            case (slc_q[k])
               SL_EMPTY: if (take_in[k]) slc_d[k] = SL_ONE;
               SL_ONE: begin
                  if (take_in[k] && !take_out[k])      slc_d[k] = SL_FULL;
                  else if (!take_in[k] && take_out[k]) slc_d[k] = SL_EMPTY;
               end
               SL_FULL:  if (take_out[k]) slc_d[k] = SL_ONE;
               default:  slc_d[k] = SL_EMPTY;
            endcase
         end
      end
   end

   always_comb begin
      ld_main      = '0;
      ld_skid      = '0;
      ld_from_skid = '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
         ld_main[k]      = take_in[k] && ((slc_q[k] == SL_EMPTY) ||
                                          (slc_q[k] == SL_ONE && take_out[k]));
         ld_skid[k]      = take_in[k] && (slc_q[k] == SL_ONE) && !take_out[k];
         ld_from_skid[k] = take_out[k] && (slc_q[k] == SL_FULL);
      end
   end

   // Payload registers carry no valid meaning; flush only clears the state above.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            main_dat[k] <= '0;
            skid_dat[k] <= '0;
         end
      end else begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            if (ld_main[k])           main_dat[k] <= dat_chain[k];
            else if (ld_from_skid[k]) main_dat[k] <= skid_dat[k];
            if (ld_skid[k])           skid_dat[k] <= dat_chain[k];
         end
      end
   end

   assign str.s_ready_o   = in_rdy[0];
   assign str.m_valid_o   = main_vld[FWD_STAGES-1];
   assign str.m_data_o    = main_dat[FWD_STAGES-1];
   assign str.occupancy_o = occ;

   if (SIDEBAND_STAGES == 0) begin : g_sb_wire
      assign sb_o = sb_i;
   end else begin : g_sb_pipe
      logic [SIDEBAND_WIDTH-1:0] sb_q [SIDEBAND_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 0; k < SIDEBAND_STAGES; k++) sb_q[k] <= '0;
         end else begin
            sb_q[0] <= sb_i;
            for (int k = 1; k < SIDEBAND_STAGES; k++) sb_q[k] <= sb_q[k-1];
         end
      end
      assign sb_o = sb_q[SIDEBAND_STAGES-1];
   end

   if (STATUS_STAGES == 0) begin : g_st_wire
      assign st_o = st_i;
   end else begin : g_st_pipe
      logic [STATUS_WIDTH-1:0] stat_q [STATUS_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 0; k < STATUS_STAGES; k++) stat_q[k] <= '0;
         end else begin
            stat_q[0] <= st_i;
            for (int k = 1; k < STATUS_STAGES; k++) stat_q[k] <= stat_q[k-1];
         end
      end
      assign st_o = stat_q[STATUS_STAGES-1];
   end
endmodule
